// File: rtl/quad_pkg.sv
// Shared constants and transition classifier for the quadrature decoder.
// Phase pairs are written {A,B}; the up rotation is 00 -> 01 -> 11 -> 10 -> 00.
package quad_pkg;

  localparam logic [1:0] PH_00 = 2'b00;
  localparam logic [1:0] PH_01 = 2'b01;
  localparam logic [1:0] PH_11 = 2'b11;
  localparam logic [1:0] PH_10 = 2'b10;

  localparam int POS_W_DEFAULT = 8;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  typedef enum logic [1:0] {
    MOVE_NONE,
    MOVE_UP,
    MOVE_DOWN,
    MOVE_ILLEGAL
  } move_t;

  function automatic move_t classify(input logic [1:0] prev, input logic [1:0] cur);
    move_t m;
    case ({prev, cur})
      {PH_00, PH_01}, {PH_01, PH_11}, {PH_11, PH_10}, {PH_10, PH_00}: m = MOVE_UP;
      {PH_00, PH_10}, {PH_10, PH_11}, {PH_11, PH_01}, {PH_01, PH_00}: m = MOVE_DOWN;
      default: m = (prev == cur) ? MOVE_NONE : MOVE_ILLEGAL;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/quad_debounce.sv
// One encoder phase: 2-flop synchroniser followed by a stability-count filter.
// The filtered output only moves after DEBOUNCE_CYCLES consecutive differing samples.
module quad_debounce
  import quad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_filt
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_filt;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_filt  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      // A sample matching the filtered value is a bounce back: restart the count.
      if (r_sync2 == r_filt) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_filt <= r_sync2;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_filt = r_filt;

endmodule

// File: rtl/quad_decoder.sv
// Rotary encoder decoder: debounced A/B phases -> step strobe, direction, wrapping position.
// Define QUAD_DEC_ERR_EN to add the sticky illegal-transition flag 'err'.
module quad_decoder
  import quad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int POS_W           = POS_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enc_a,
  input  logic             enc_b,
  output logic             step,
  output logic             up_down,
  output logic [POS_W-1:0] pos,
  output logic [7:0]       led
`ifdef QUAD_DEC_ERR_EN
  ,
  output logic             err
`endif
);

  logic [1:0]       w_raw;
  logic [1:0]       w_filt;
  move_t            w_move;
  logic [POS_W-1:0] w_pos_next;
  logic [7:0]       w_led_next;

  logic [1:0]       r_prev;
  logic             r_step;
  logic             r_up_down;
  logic [POS_W-1:0] r_pos;
  logic [7:0]       r_led;

  assign w_raw = {enc_a, enc_b};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_phase
      quad_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
        .clk   (clk),
        .rst   (rst),
        .i_raw (w_raw[gi]),
        .o_filt(w_filt[gi])
      );
    end
  endgenerate

  assign w_move = classify(r_prev, w_filt);

  always_comb begin
    w_pos_next = r_pos;
    case (w_move)
      MOVE_UP:   w_pos_next = r_pos + POS_W'(1);
      MOVE_DOWN: w_pos_next = r_pos - POS_W'(1);
      default:   w_pos_next = r_pos;
    endcase
  end

  generate
    if (POS_W >= 8) begin : g_led_trunc
      assign w_led_next = w_pos_next[7:0];
    end else begin : g_led_pad
      assign w_led_next = {{(8 - POS_W){1'b0}}, w_pos_next};
    end
  endgenerate

  // Previous pair always follows the filtered pair, so an illegal jump resynchronises.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev    <= PH_00;
      r_step    <= 1'b0;
      r_up_down <= DIR_UP;
      r_pos     <= '0;
      r_led     <= '0;
    end else begin
      r_prev <= w_filt;
      r_step <= (w_move == MOVE_UP) || (w_move == MOVE_DOWN);
      if (w_move == MOVE_UP) begin
        r_up_down <= DIR_UP;
      end else if (w_move == MOVE_DOWN) begin
        r_up_down <= DIR_DOWN;
      end
      r_pos <= w_pos_next;
      r_led <= w_led_next;
    end
  end

`ifdef QUAD_DEC_ERR_EN
  logic r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_move == MOVE_ILLEGAL) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`endif

  assign step    = r_step;
  assign up_down = r_up_down;
  assign pos     = r_pos;
  assign led     = r_led;

endmodule

// File: tb/tb_quad_decoder.sv
// Self-checking bench for quad_decoder: directed scenarios plus a randomized walk
// checked cycle by cycle against a sample-window reference model.
module tb_quad_decoder;

  localparam int D = 4;
`ifdef QUAD_DEC_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enc_a = 1'b0;
  logic       enc_b = 1'b0;
  logic       step;
  logic       up_down;
  logic [7:0] pos;
  logic [7:0] led;
  logic       err_obs;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

`ifdef QUAD_DEC_ERR_EN
  logic err;
  assign err_obs = err;
`else
  assign err_obs = 1'b0;
`endif

  quad_decoder #(
    .DEBOUNCE_CYCLES(D),
    .POS_W(8)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .enc_a  (enc_a),
    .enc_b  (enc_b),
    .step   (step),
    .up_down(up_down),
    .pos    (pos),
`ifdef QUAD_DEC_ERR_EN
    .led    (led),
    .err    (err)
`else
    .led    (led)
`endif
  );

  // Reference model: raw pin samples per edge, filtered values, position on the rotation ring.
  bit       q_a[$];
  bit       q_b[$];
  bit       m_fa, m_fb;
  bit [1:0] m_prev;
  bit       m_step, m_ud, m_err;
  bit [7:0] m_pos;
  int       dut_steps = 0;
  bit [1:0] ring [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

  function automatic int ring_idx(input bit [1:0] p);
    for (int i = 0; i < 4; i++) if (ring[i] == p) return i;
    return 0;
  endfunction

  // Filtered value moves to v once the D samples that have cleared the synchroniser all equal v.
  function automatic bit filt_next(input bit q[$], input bit f);
    int n;
    bit v;
    n = q.size();
    v = q[n-3];
    for (int i = 0; i < D; i++) if (q[n-3-i] != v) return f;
    return v;
  endfunction

  task automatic model_edge();
    int delta;
    bit [1:0] cur;
    if (rst) begin
      q_a.delete();
      q_b.delete();
      for (int i = 0; i < D + 2; i++) begin
        q_a.push_back(1'b0);
        q_b.push_back(1'b0);
      end
      m_fa = 0; m_fb = 0; m_prev = 2'b00;
      m_step = 0; m_ud = 1; m_pos = 8'h00; m_err = 0;
      return;
    end
    cur = {m_fa, m_fb};
    delta = (ring_idx(cur) - ring_idx(m_prev) + 4) % 4;
    m_step = 0;
    if (delta == 1) begin
      m_step = 1; m_ud = 1; m_pos = m_pos + 8'd1;
    end else if (delta == 3) begin
      m_step = 1; m_ud = 0; m_pos = m_pos - 8'd1;
    end else if (delta == 2) begin
      m_err = 1;
    end
    m_prev = cur;
    q_a.push_back(enc_a);
    q_b.push_back(enc_b);
    m_fa = filt_next(q_a, m_fa);
    m_fb = filt_next(q_b, m_fb);
    while (q_a.size() > D + 2) void'(q_a.pop_front());
    while (q_b.size() > D + 2) void'(q_b.pop_front());
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    if (step === 1'b1) dut_steps++;
  endtask

  task automatic apply_reset(input int n);
    rst = 1'b1;
    repeat (n) tick();
    rst = 1'b0;
    dut_steps = 0;
  endtask

  task automatic hold_pair(input bit [1:0] p, input int n);
    {enc_a, enc_b} = p;
    repeat (n) tick();
  endtask

  task automatic test_reset();
    enc_a = 0; enc_b = 0;
    apply_reset(3);
    tests_run++;
    if ({step, up_down, pos, led, err_obs} !== {1'b0, 1'b1, 8'h00, 8'h00, 1'b0}) begin
      tests_failed++;
      $display("FAIL reset_values: step=%b up_down=%b pos=%h led=%h err=%b, want 0 1 00 00 0",
               step, up_down, pos, led, err_obs);
    end
    repeat (20) tick();
    tests_run++;
    if (dut_steps != 0 || pos !== 8'h00 || led !== 8'h00 || up_down !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_idle: steps=%0d pos=%h led=%h up_down=%b, want 0 00 00 1",
               dut_steps, pos, led, up_down);
    end
    $display("[TB] test_reset done");
  endtask

  task automatic test_up_sequence();
    bit [1:0] seq [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
    int lat;
    apply_reset(2);
    lat = -1;
    {enc_a, enc_b} = seq[0];
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (step === 1'b1 && lat < 0) lat = c;
    end
    tests_run++;
    if (lat != 7) begin
      tests_failed++;
      $display("FAIL up_latency: first step after %0d cycles, want 7", lat);
    end
    for (int i = 1; i < 4; i++) hold_pair(seq[i], 10);
    tests_run++;
    if (dut_steps != 4 || pos !== 8'h04 || led !== 8'h04 || up_down !== 1'b1) begin
      tests_failed++;
      $display("FAIL up_four: steps=%0d pos=%h led=%h up_down=%b, want 4 04 04 1",
               dut_steps, pos, led, up_down);
    end
    $display("[TB] test_up_sequence done: pos=%h", pos);
  endtask

  task automatic test_down_wrap();
    apply_reset(2);
    hold_pair(2'b10, 10);
    tests_run++;
    if (dut_steps != 1 || pos !== 8'hFF || led !== 8'hFF || up_down !== 1'b0) begin
      tests_failed++;
      $display("FAIL down_wrap: steps=%0d pos=%h led=%h up_down=%b, want 1 ff ff 0",
               dut_steps, pos, led, up_down);
    end
    $display("[TB] test_down_wrap done: pos=%h", pos);
  endtask

  task automatic test_bounce();
    apply_reset(2);
    enc_a = 0; enc_b = 0;
    for (int i = 0; i < 10; i++) begin
      enc_b = ~enc_b;
      repeat (2) tick();
    end
    enc_b = 1'b1;
    repeat (12) tick();
    tests_run++;
    if (dut_steps != 1 || pos !== 8'h01 || up_down !== 1'b1) begin
      tests_failed++;
      $display("FAIL bounce: steps=%0d pos=%h up_down=%b, want 1 01 1", dut_steps, pos, up_down);
    end
    $display("[TB] test_bounce done: pos=%h", pos);
  endtask

  task automatic test_illegal();
    apply_reset(2);
    hold_pair(2'b11, 10);
    tests_run++;
    if (dut_steps != 0 || pos !== 8'h00 || up_down !== 1'b1 || err_obs !== ERR_EN) begin
      tests_failed++;
      $display("FAIL illegal_jump: steps=%0d pos=%h up_down=%b err=%b, want 0 00 1 %b",
               dut_steps, pos, up_down, err_obs, ERR_EN);
    end
    hold_pair(2'b10, 10);
    hold_pair(2'b00, 10);
    tests_run++;
    if (dut_steps != 2 || pos !== 8'h02 || err_obs !== ERR_EN) begin
      tests_failed++;
      $display("FAIL illegal_resync: steps=%0d pos=%h err=%b, want 2 02 %b",
               dut_steps, pos, err_obs, ERR_EN);
    end
    apply_reset(1);
    tests_run++;
    if (err_obs !== 1'b0) begin
      tests_failed++;
      $display("FAIL err_clear: err=%b, want 0", err_obs);
    end
    $display("[TB] test_illegal done");
  endtask

  task automatic test_reset_mid();
    bit [1:0] seq [5] = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b01};
    apply_reset(2);
    for (int i = 0; i < 5; i++) hold_pair(seq[i], 10);
    tests_run++;
    if (pos !== 8'h05) begin
      tests_failed++;
      $display("FAIL pre_reset_pos: pos=%h, want 05", pos);
    end
    hold_pair(2'b11, 4);
    rst = 1'b1;
    tick();
    tests_run++;
    if ({step, up_down, pos, led} !== {1'b0, 1'b1, 8'h00, 8'h00}) begin
      tests_failed++;
      $display("FAIL mid_reset: step=%b up_down=%b pos=%h led=%h, want 0 1 00 00",
               step, up_down, pos, led);
    end
    rst = 1'b0;
    dut_steps = 0;
    repeat (15) tick();
    tests_run++;
    if (dut_steps != 0 || pos !== 8'h00 || err_obs !== (m_err & ERR_EN)) begin
      tests_failed++;
      $display("FAIL post_reset: steps=%0d pos=%h err=%b, want 0 00 %b",
               dut_steps, pos, err_obs, m_err & ERR_EN);
    end
    $display("[TB] test_reset_mid done");
  endtask

  task automatic test_random();
    bit [1:0] cur, nxt;
    int r, hold;
    apply_reset(2);
    for (int seg = 0; seg < 60; seg++) begin
      cur = {enc_a, enc_b};
      r = $urandom_range(0, 9);
      if (r < 4)      nxt = ring[(ring_idx(cur) + 1) % 4];
      else if (r < 8) nxt = ring[(ring_idx(cur) + 3) % 4];
      else            nxt = 2'($urandom_range(0, 3));
      {enc_a, enc_b} = nxt;
      hold = $urandom_range(1, 12);
      if ($urandom_range(0, 19) == 0) rst = 1'b1;
      for (int c = 0; c < hold; c++) begin
        tick();
        rst = 1'b0;
        tests_run++;
        if ({step, up_down, pos, led, err_obs} !== {m_step, m_ud, m_pos, m_pos, m_err & ERR_EN}) begin
          tests_failed++;
          $display("FAIL random seg%0d: step=%b ud=%b pos=%h led=%h err=%b, want %b %b %h %h %b",
                   seg, step, up_down, pos, led, err_obs,
                   m_step, m_ud, m_pos, m_pos, m_err & ERR_EN);
        end
      end
      $display("[TB] random seg %0d: pair=%b hold=%0d pos=%h", seg, nxt, hold, pos);
    end
  endtask

  initial begin
    test_reset();
    test_up_sequence();
    test_down_wrap();
    test_bounce();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
